// File: rtl/sw_debounce.sv
// Per-channel switch/key debouncer: clean level plus one-cycle rise/fall pulses.
// Optional 2-flop input synchroniser enabled by defining DEBOUNCE_SYNC_EN.
module sw_debounce #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned CNT_MAX = 1000000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_LO = 2'd0,
        W_HI = 2'd1,
        S_HI = 2'd2,
        W_LO = 2'd3
    } state_t;

    logic [WIDTH-1:0] s;
    state_t           state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    // Two-flop synchroniser for inputs arriving straight from pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = in;
`endif

    // Per-channel debounce FSM; a change is accepted only after CNT_MAX stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state[i] <= S_LO;
                cnt[i]   <= '0;
            end
            out  <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                case (state[i])
                    S_LO: begin
                        if (s[i]) begin
                            state[i] <= W_HI;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    W_HI: begin
                        if (!s[i]) begin
                            state[i] <= S_LO;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i] <= S_HI;
                            cnt[i]   <= '0;
                            out[i]   <= 1'b1;
                            rise[i]  <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    S_HI: begin
                        if (!s[i]) begin
                            state[i] <= W_LO;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    W_LO: begin
                        if (s[i]) begin
                            state[i] <= S_HI;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i] <= S_LO;
                            cnt[i]   <= '0;
                            out[i]   <= 1'b0;
                            fall[i]  <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= S_LO;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed literal checks plus randomized run against a run-length model.
module tb_sw_debounce;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned CNT_MAX = 4;
    localparam int unsigned CNT_W   = 3;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int n_cmp = 0;
    int n_bad = 0;

    sw_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .out  (out),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    // Model: count consecutive samples that disagree with the output; flip at CNT_MAX
    int          run [WIDTH];
    logic [2:0]  m_out, m_rise, m_fall;
    logic [2:0]  m_p1, m_p2, m_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) run[i] = 0;
            m_out = '0; m_rise = '0; m_fall = '0;
            m_p1 = '0; m_p2 = '0;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            m_s = m_p2;
`else
            m_s = in;
`endif
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 3; i++) begin
                if (m_s[i] != m_out[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == int'(CNT_MAX)) begin
                        m_out[i] = m_s[i];
                        if (m_s[i]) m_rise[i] = 1'b1;
                        else        m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = in;
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, sampled after the active edge
    always @(posedge clk) begin
        #3;
        chk("model_out",  out,  m_out);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
        chk("rise_and_fall", rise & fall, 3'b000);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] v);
        rst_n = 1'b0;
        in    = v;
        tick();
        rst_n = 1'b1;
    endtask

    int hold [WIDTH];

    initial begin
        rst_n = 1'b0;
        in    = 3'b111;
        // Reset held with inputs high: everything stays 0
        repeat (3) begin
            tick();
            chk("rst_out", out, 3'b000);
            chk("rst_pulse", rise | fall, 3'b000);
        end
        rst_n = 1'b1;
        repeat (LAT - 1) begin tick(); chk("rel_rise_early", rise, 3'b000); end
        tick();
        chk("rel_rise", rise, 3'b111);
        chk("rel_out", out, 3'b111);
        tick();
        chk("rel_rise_once", rise, 3'b000);
        chk("rel_out_hold", out, 3'b111);

        // Clean press on channel 0
        do_reset(3'b000);
        tick(); tick();
        in = 3'b001;
        repeat (LAT - 1) begin tick(); chk("press_early", rise | out, 3'b000); end
        tick();
        chk("press_rise", rise, 3'b001);
        chk("press_out", out, 3'b001);
        chk("press_fall", fall, 3'b000);
        tick();
        chk("press_once", rise, 3'b000);

        // Bounce on channel 1: 3 high, 1 low, then held high
        in[1] = 1'b1;
        repeat (3) tick();
        in[1] = 1'b0;
        tick();
        in[1] = 1'b1;
        repeat (LAT - 1) begin tick(); chk("bounce_quiet", rise | fall, 3'b000); end
        tick();
        chk("bounce_rise", rise, 3'b010);
        chk("bounce_out", out, 3'b011);

        // Release of channel 2, then a short low glitch
        in[2] = 1'b1;
        repeat (LAT + 2) tick();
        chk("rel2_out_hi", out, 3'b111);
        in[2] = 1'b0;
        repeat (LAT - 1) begin tick(); chk("fall_early", fall, 3'b000); end
        tick();
        chk("fall_pulse", fall, 3'b100);
        chk("fall_out", out, 3'b011);
        in[2] = 1'b1;
        repeat (LAT + 2) tick();
        in[2] = 1'b0;
        repeat (3) tick();
        in[2] = 1'b1;
        repeat (LAT + 4) begin
            tick();
            chk("glitch_fall", fall, 3'b000);
            chk("glitch_out", out, 3'b111);
        end

        // Reset in the middle of a wait on channel 0
        do_reset(3'b000);
        tick();
        in = 3'b001;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out", out, 3'b000);
        rst_n = 1'b1;
        repeat (LAT - 1) begin tick(); chk("midrst_early", rise, 3'b000); end
        tick();
        chk("midrst_rise", rise, 3'b001);

        // Randomized levels with varied hold lengths and occasional resets
        for (int i = 0; i < 3; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 3; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    in[i]   = ~in[i];
                    hold[i] = int'($urandom_range(1, CNT_MAX + 3));
                end
            end
        end
        rst_n = 1'b1;
        repeat (LAT + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
